// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scans four BCD digits onto a shared 4-anode, active-low
// 7-segment display. Each slot starts with a blanking interval to stop ghosting.
// New values are double-buffered and only reach the display at frame boundaries.
// Optional feature macro: LEAD_ZERO_BLANK_EN (blanks leading zeros on digits 3..1).
module seg_scan_ctrl #(
    parameter int SLOT_CYC  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        load,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [0:0]    r_state;
    logic [15:0]   r_disp;
    logic [15:0]   r_pend;
    logic          r_pendValid;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;

    logic [CW-1:0] w_cntNext;
    logic [1:0]    w_idxNext;
    logic [0:0]    w_stateNext;
    logic [15:0]   w_dispNext;
    logic [15:0]   w_pendNext;
    logic          w_pendValidNext;
    logic          w_slotEnd;
    logic          w_frameEnd;
    logic [3:0]    w_digit;
    logic [3:0]    w_lzMask;
    logic [3:0]    w_anNext;
    logic [7:0]    w_segNext;

    // BCD to active-low segments, bit7..bit0 = a,b,c,d,e,f,g,DP; non-BCD codes light everything
    function automatic logic [7:0] bcdSeg(input logic [3:0] d);
        case (d)
            4'd0:    bcdSeg = 8'h03;
            4'd1:    bcdSeg = 8'h9F;
            4'd2:    bcdSeg = 8'h25;
            4'd3:    bcdSeg = 8'h0D;
            4'd4:    bcdSeg = 8'h99;
            4'd5:    bcdSeg = 8'h49;
            4'd6:    bcdSeg = 8'h41;
            4'd7:    bcdSeg = 8'h1F;
            4'd8:    bcdSeg = 8'h01;
            4'd9:    bcdSeg = 8'h09;
            default: bcdSeg = 8'h00;
        endcase
    endfunction

    assign w_slotEnd   = (r_cnt == CNT_LAST);
    assign w_frameEnd  = w_slotEnd && (r_idx == 2'd3);
    assign w_cntNext   = w_slotEnd ? '0 : r_cnt + CW'(1);
    assign w_idxNext   = w_slotEnd ? r_idx + 2'd1 : r_idx;
    assign w_stateNext = (w_cntNext < CNT_SHOW) ? ST_BLANK : ST_SHOW;

    // Double-buffer handshake: last load in a frame wins, swap only on the frame's last cycle
    always_comb begin
        w_dispNext      = r_disp;
        w_pendNext      = r_pend;
        w_pendValidNext = r_pendValid;
        if (w_frameEnd) begin
            if (load)
                w_dispNext = din;
            else if (r_pendValid)
                w_dispNext = r_pend;
            w_pendValidNext = 1'b0;
        end else if (load) begin
            w_pendNext      = din;
            w_pendValidNext = 1'b1;
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows
    always_comb begin
        w_lzMask    = 4'b0000;
        w_lzMask[3] = (w_dispNext[15:12] == 4'd0);
        w_lzMask[2] = w_lzMask[3] && (w_dispNext[11:8] == 4'd0);
        w_lzMask[1] = w_lzMask[2] && (w_dispNext[7:4] == 4'd0);
    end
`else
    assign w_lzMask = 4'b0000;
`endif

    // Pick the digit of the slot being entered so outputs line up with the counter
    always_comb begin
        case (w_idxNext)
            2'd0:    w_digit = w_dispNext[3:0];
            2'd1:    w_digit = w_dispNext[7:4];
            2'd2:    w_digit = w_dispNext[11:8];
            default: w_digit = w_dispNext[15:12];
        endcase
    end

    // Output decode from next state so the registered pins carry no extra cycle of lag
    always_comb begin
        w_anNext  = 4'b1111;
        w_segNext = 8'hFF;
        if (w_stateNext == ST_SHOW) begin
            w_anNext  = ~(4'b0001 << w_idxNext);
            w_segNext = w_lzMask[w_idxNext] ? 8'hFF : bcdSeg(w_digit);
        end
    end

    // State, buffers and output registers; reset blanks the display immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_state     <= ST_BLANK;
            r_disp      <= 16'h0000;
            r_pend      <= 16'h0000;
            r_pendValid <= 1'b0;
            r_an        <= 4'b1111;
            r_seg       <= 8'hFF;
        end else begin
            r_cnt       <= w_cntNext;
            r_idx       <= w_idxNext;
            r_state     <= w_stateNext;
            r_disp      <= w_dispNext;
            r_pend      <= w_pendNext;
            r_pendValid <= w_pendValidNext;
            r_an        <= w_anNext;
            r_seg       <= w_segNext;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign digit_idx  = r_idx;
    assign frame_done = w_frameEnd;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and random stimulus for seg_scan_ctrl, compared
// each cycle against a frame-level model derived from elapsed cycles since reset.
module tb_seg_scan_ctrl;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * SLOT;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        load;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int          vecCount;
    int          errCount;
    int          tick;
    logic [15:0] mDisp;
    logic [15:0] mPend;
    logic        mPendValid;

    seg_scan_ctrl #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] segOf(input logic [3:0] d);
        logic [7:0] tbl [0:9];
        tbl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
        if (d > 4'd9) return 8'h00;
        return tbl[d];
    endfunction

    task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s at tick %0d: observed %h expected %h", tag, tick, obs, exp);
        end
    endtask

    // Expected outputs follow directly from the cycle count and the displayed value
    task automatic checkOutput();
        int          cnt;
        int          slot;
        logic [3:0]  dig;
        logic [15:0] upper;
        logic [3:0]  expAn;
        logic [7:0]  expSeg;
        cnt   = tick % SLOT;
        slot  = (tick / SLOT) % 4;
        dig   = 4'((mDisp >> (slot * 4)) & 16'h000F);
        upper = mDisp >> (slot * 4);
        if (cnt < BLANK) begin
            expAn  = 4'b1111;
            expSeg = 8'hFF;
        end else begin
            expAn  = ~(4'b0001 << slot);
            expSeg = segOf(dig);
`ifdef LEAD_ZERO_BLANK_EN
            if (slot > 0 && upper == 16'h0000) expSeg = 8'hFF;
`endif
        end
        check1("an", {4'h0, an}, {4'h0, expAn});
        check1("seg", seg, expSeg);
        check1("digit_idx", {6'h0, digit_idx}, 8'(slot));
        check1("frame_done", {7'h0, frame_done}, {7'h0, (tick % FRAME) == FRAME - 1});
    endtask

    // One clock with the given load/din; the model advances on the same edge
    task automatic applyStimulus(input logic ld, input logic [15:0] d);
        logic fd;
        load = ld;
        din  = d;
        @(posedge clk);
        fd = (tick % FRAME) == FRAME - 1;
        if (ld && fd) begin
            mDisp      = d;
            mPendValid = 1'b0;
        end else if (ld) begin
            mPend      = d;
            mPendValid = 1'b1;
        end else if (fd && mPendValid) begin
            mDisp      = mPend;
            mPendValid = 1'b0;
        end
        tick++;
        #1;
        load = 1'b0;
        checkOutput();
    endtask

    task automatic runTo(input int phase);
        applyStimulus(1'b0, 16'h0);
        while ((tick % FRAME) != phase) applyStimulus(1'b0, 16'h0);
    endtask

    initial begin
        vecCount   = 0;
        errCount   = 0;
        tick       = 0;
        mDisp      = 16'h0;
        mPend      = 16'h0;
        mPendValid = 1'b0;
        rst        = 1'b1;
        load       = 1'b0;
        din        = 16'h0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        checkOutput();

        // idle scan of zeros across two frames
        repeat (2 * FRAME) applyStimulus(1'b0, 16'h0);

        // mid-frame load, held off until the frame boundary
        runTo(12);
        applyStimulus(1'b1, 16'h1234);
        repeat (2 * FRAME) applyStimulus(1'b0, 16'h0);

        // two loads in one frame, the later one wins
        runTo(5);
        applyStimulus(1'b1, 16'h1111);
        repeat (7) applyStimulus(1'b0, 16'h0);
        applyStimulus(1'b1, 16'h9876);
        repeat (2 * FRAME) applyStimulus(1'b0, 16'h0);

        // load on the frame_done cycle goes straight to the display
        runTo(FRAME - 1);
        applyStimulus(1'b1, 16'h4321);
        repeat (FRAME) applyStimulus(1'b0, 16'h0);

        // non-BCD digit and leading zeros
        runTo(20);
        applyStimulus(1'b1, 16'h00A5);
        repeat (2 * FRAME) applyStimulus(1'b0, 16'h0);

        // random loads, some aimed at the frame boundary
        for (int i = 0; i < 400; i++) begin
            if ((tick % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1)
                applyStimulus(1'b1, 16'($urandom));
            else
                applyStimulus($urandom_range(0, 15) == 0, 16'($urandom));
        end

        // asynchronous reset during SHOW of slot 2
        runTo(2 * SLOT + 4);
        #2;
        rst = 1'b1;
        #1;
        check1("rst_an", {4'h0, an}, 8'h0F);
        check1("rst_seg", seg, 8'hFF);
        check1("rst_idx", {6'h0, digit_idx}, 8'h00);
        @(negedge clk);
        rst        = 1'b0;
        tick       = 0;
        mDisp      = 16'h0;
        mPend      = 16'h0;
        mPendValid = 1'b0;
        checkOutput();
        repeat (FRAME + 4) applyStimulus(1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
